// File: rtl/seq_wide_adder_pkg.sv
// Shared definitions for the sequential wide adder.
//   state_e   : FSM state encoding (IDLE, RUN, DONE)
//   N_DEFAULT : default slice width (width of the shared adder)
//   M_DEFAULT : default number of slices
package seq_wide_adder_pkg;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned M_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_wide_adder_fulladd4.sv
// Parameterised N-bit ripple-carry adder (fulladd4), used as the shared
// per-slice datapath of seq_wide_adder.
//   a, b  : N-bit addends
//   c_in  : carry into bit 0
//   sum   : N-bit sum
//   c_out : carry out of bit N-1
module fulladd4 #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = c[N];

endmodule

// File: rtl/seq_wide_adder.sv
// Sequential W = N*M bit adder: one N-bit slice per cycle on a single
// shared ripple-carry adder, with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b, c_in          : W-bit operands and carry in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, c_out          : result, held from DONE until the next accept
//   busy                : state is not IDLE
module seq_wide_adder
  import seq_wide_adder_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = M_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*M-1:0] a,
  input  logic [N*M-1:0] b,
  input  logic           c_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*M-1:0] sum,
  output logic           c_out,
  output logic           busy
);

  localparam int unsigned W  = N * M;
  localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;

  logic [N-1:0]    slice_a, slice_b, slice_sum;
  logic            slice_c;

  assign slice_a = a_q[k_q*N +: N];
  assign slice_b = b_q[k_q*N +: N];

  fulladd4 #(.N(N)) u_add (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_c)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[k_q*N +: N] = slice_sum;
        carry_d           = slice_c;
        // Counter parks at the last slice rather than wrapping.
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
    end
  end

  // The carry register holds the top-slice carry once DONE is reached.
  assign sum   = sum_q;
  assign c_out = carry_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: doc/seq_wide_adder.md
SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

Interface
REQ-001 SHALL have parameter N, default 4: slice width in bits, which is the width of the shared adder.
REQ-002 SHALL have parameter M, default 4: number of slices; the operand width W = N*M; M >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have port a, input, W bits: operand A.
REQ-008 SHALL have port b, input, W bits: operand B.
REQ-009 SHALL have port c_in, input, 1 bit: carry into slice 0.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port sum, output, W bits: (a+b+c_in) mod 2^W.
REQ-013 SHALL have port c_out, output, 1 bit: the carry out of the top slice.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL drive out_valid=1 only in DONE.
REQ-018 SHALL accept a request on a rising edge where in_valid=1 and state=IDLE; on that edge it SHALL:
  - capture a, b and c_in into internal registers;
  - clear the slice counter;
  - move to RUN.
REQ-019 SHALL, in RUN, evaluate one slice k per cycle (k = 0..M-1) on the shared N-bit adder, with inputs:
  - the operand A bits [kN+N-1 : kN];
  - the operand B bits [kN+N-1 : kN];
  - the carry register.
REQ-020 SHALL, at each RUN edge, write the adder sum into sum bits [kN+N-1 : kN], load the adder carry into the carry register, and increment k.
REQ-021 SHALL use exactly one N-bit adder instance; no second adder and no W-bit "+" operator are allowed.
REQ-022 SHALL move from RUN to DONE on the edge that processes slice M-1, so out_valid rises exactly M edges after the accepting edge.
REQ-023 SHALL set c_out equal to the carry register value after slice M-1.
REQ-024 SHALL hold sum and c_out stable throughout DONE, and SHALL leave them unchanged until the next accept.
REQ-025 SHALL move from DONE to IDLE on an edge where out_ready=1.
REQ-026 SHALL stay in DONE indefinitely while out_ready=0.
REQ-027 SHALL ignore in_valid, a, b and c_in whenever the state is not IDLE; no request is queued.
REQ-028 SHALL give a back-to-back throughput of one result per M+2 cycles when in_valid=1 and out_ready=1 are held high.
REQ-029 SHALL, for M=1, complete in a single RUN cycle and still pass through DONE.
REQ-030 SHALL keep the slice counter in the range 0..M-1 with no wrap inside an operation.
REQ-031 SHALL treat all arithmetic as unsigned and discard overflow beyond W bits, reporting it only through c_out.

Reset
REQ-032 SHALL, while rst_n=0, immediately force the state to IDLE and set:
  - in_ready = 1;
  - out_valid = 0;
  - busy = 0;
  - sum = 0;
  - c_out = 0;
  - the carry register, slice counter and operand registers to 0.
REQ-033 SHALL, when reset is asserted mid-RUN or in DONE, abort the operation with no result emitted, and SHALL accept the first request on the first rising edge after rst_n is released.

Structure
REQ-034 SHALL place in a shared package: the FSM state enumeration (IDLE, RUN, DONE) and the default values of N and M.
REQ-035 SHALL derive the slice-counter width locally as clog2(M), with a minimum of 1.
REQ-036 SHALL instantiate exactly one sub-module, the team's existing parameterised N-bit ripple-carry adder (fulladd4 with parameter N), as the shared datapath.
REQ-037 SHALL keep the sequencing logic (FSM, counter, operand/result registers) in seq_wide_adder itself.

Verification
REQ-038 SHALL cover, with N=4, M=4: a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1, out_valid rising 4 edges after accept.
REQ-039 SHALL cover: a=16'h1234, b=16'h4321, c_in=1 -> sum=16'h5556, c_out=0.
REQ-040 SHALL cover backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> sum held, in_ready=0, no new accept; out_ready=1 -> IDLE on the next edge.
REQ-041 SHALL cover reset mid-operation: rst_n pulsed low during the 2nd RUN cycle -> out_valid never rises, outputs 0, and the next request a=16'h0005, b=16'h0003 -> sum=16'h0008.
REQ-042 SHALL cover streaming: in_valid=1 and out_ready=1 held with 10 random operand pairs -> each sum and c_out match a reference model, with accepts spaced exactly 6 cycles apart.
REQ-043 SHALL cover M=1, N=8: a=8'hF0, b=8'h10 -> sum=8'h00, c_out=1, out_valid 1 edge after accept.
